// File: rtl/sprites_pkg.sv
// Shared VGA timing constants, palette and 7-segment decode for the sprites demo.
package sprites_pkg;

   localparam logic [9:0] H_LAST       = 10'd799;
   localparam logic [9:0] V_LAST       = 10'd524;
   localparam logic [9:0] H_VIS        = 10'd640;
   localparam logic [9:0] V_VIS        = 10'd480;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd751;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd491;
   localparam logic [9:0] WIN_SIZE     = 10'd256;
   localparam logic [9:0] FRAME_ROW    = 10'd480;
   localparam logic [7:0] SPR_MAX      = 8'd240;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   function automatic rgb_t palette(input logic [1:0] idx);
      case (idx)
         2'd0:    return rgb_t'{3'd0, 3'd0, 3'd0};
         2'd1:    return rgb_t'{3'd7, 3'd0, 3'd0};
         2'd2:    return rgb_t'{3'd0, 3'd7, 3'd0};
         default: return rgb_t'{3'd7, 3'd7, 3'd7};
      endcase
   endfunction

   // Returns {A,B,C,D,E,F,G}, active-low.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h7B;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h4E;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return ~seg;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Raw 800x525 column/row counters with combinational active-low syncs.
module vga_timing
   import sprites_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       hsync,
   output logic       vsync
);

   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (col == H_LAST) begin
         col <= '0;
         row <= (row == V_LAST) ? 10'd0 : row + 10'd1;
      end else begin
         col <= col + 10'd1;
      end
   end

   assign hsync = !(col >= H_SYNC_START && col <= H_SYNC_END);
   assign vsync = !(row >= V_SYNC_START && row <= V_SYNC_END);

endmodule

// File: rtl/sprites.sv
// VGA demo top: tiled 256x256 playfield with a switch-steered 16x16 sprite,
// two-stage pixel pipeline (ROM lookup, then compose/palette).
module sprites
   import sprites_pkg::*;
#(
   parameter int WIN_X0   = 16,
   parameter int SPR_INIT = 120
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Switch_1,
   input  logic       i_Switch_2,
   input  logic       i_Switch_3,
   input  logic       i_Switch_4,
   output logic       o_VGA_HSync,
   output logic       o_VGA_VSync,
   output logic       o_VGA_Red_0,
   output logic       o_VGA_Red_1,
   output logic       o_VGA_Red_2,
   output logic       o_VGA_Grn_0,
   output logic       o_VGA_Grn_1,
   output logic       o_VGA_Grn_2,
   output logic       o_VGA_Blu_0,
   output logic       o_VGA_Blu_1,
   output logic       o_VGA_Blu_2,
   output logic       o_Segment1_A,
   output logic       o_Segment1_B,
   output logic       o_Segment1_C,
   output logic       o_Segment1_D,
   output logic       o_Segment1_E,
   output logic       o_Segment1_F,
   output logic       o_Segment1_G,
   output logic       o_Segment2_A,
   output logic       o_Segment2_B,
   output logic       o_Segment2_C,
   output logic       o_Segment2_D,
   output logic       o_Segment2_E,
   output logic       o_Segment2_F,
   output logic       o_Segment2_G,
   output logic       o_LED_1,
   output logic       o_LED_2,
   output logic       o_LED_3,
   output logic       o_LED_4,
   output logic [9:0] tb_row,
   output logic [9:0] tb_column,
   output logic [1:0] tb_pixel
);

   localparam logic [9:0] WX0    = 10'(WIN_X0);
   localparam logic [9:0] WX_END = 10'(WIN_X0 + 256);
   localparam logic [7:0] S_INIT = 8'(SPR_INIT);

   function automatic logic [1:0] tile_pixel(input logic [7:0] wx, input logic [7:0] wy);
      logic [1:0] idx;
      logic [3:0] px, py;
      idx = wx[5:4] + wy[5:4];
      px  = wx[3:0];
      py  = wy[3:0];
      case (idx)
         2'd0:    return 2'd0;
         2'd1:    return (px == 4'd0 || px == 4'd15 || py == 4'd0 || py == 4'd15) ? 2'd1 : 2'd0;
         2'd2:    return (px[0] ^ py[0]) ? 2'd2 : 2'd0;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic sprite_opaque(input logic [7:0] lx, input logic [7:0] ly);
      return lx >= 8'd2 && lx <= 8'd13 && ly >= 8'd2 && ly <= 8'd13;
   endfunction

   logic [9:0] col, row;
   logic       hsync_raw, vsync_raw;

   vga_timing u_timing (
      .clk   (i_Clk),
      .reset (i_Reset),
      .col   (col),
      .row   (row),
      .hsync (hsync_raw),
      .vsync (vsync_raw)
   );

   logic [7:0] sx, sy;
   logic [3:0] sw_meta, sw_sync;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
         sx      <= S_INIT;
         sy      <= S_INIT;
      end else begin
         sw_meta <= {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
         sw_sync <= sw_meta;
         // Move once per frame, in vertical blanking so the picture never tears.
         if (row == FRAME_ROW && col == 10'd0) begin
            if (sw_sync[0] && !sw_sync[1] && sy != 8'd0)
               sy <= sy - 8'd1;
            else if (sw_sync[1] && !sw_sync[0] && sy < SPR_MAX)
               sy <= sy + 8'd1;
            if (sw_sync[2] && !sw_sync[3] && sx != 8'd0)
               sx <= sx - 8'd1;
            else if (sw_sync[3] && !sw_sync[2] && sx < SPR_MAX)
               sx <= sx + 8'd1;
         end
      end
   end

   logic [7:0] wx;
   logic       in_win;
   logic [1:0] tile_c;
   logic       spr_c;

   // Window-relative x wraps cleanly in 8 bits because the window is 256 wide.
   always_comb begin
      wx     = col[7:0] - WX0[7:0];
      in_win = (row < WIN_SIZE) && (col >= WX0) && (col < WX_END);
      tile_c = tile_pixel(wx, row[7:0]);
      spr_c  = sprite_opaque(wx - sx, row[7:0] - sy);
   end

   logic [9:0] s1_col, s1_row;
   logic       s1_win, s1_spr, s1_hs, s1_vs;
   logic [1:0] s1_tile;
   logic [1:0] comp_pix;
   logic       visible;
   rgb_t       rgb;
   logic       hs, vs;

   always_comb begin
      comp_pix = s1_win ? (s1_spr ? 2'd3 : s1_tile) : 2'd0;
      visible  = (s1_col < H_VIS) && (s1_row < V_VIS);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         s1_col    <= '0;
         s1_row    <= '0;
         s1_win    <= 1'b0;
         s1_spr    <= 1'b0;
         s1_tile   <= '0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         tb_column <= '0;
         tb_row    <= '0;
         tb_pixel  <= '0;
         rgb       <= '0;
         hs        <= 1'b1;
         vs        <= 1'b1;
      end else begin
         s1_col    <= col;
         s1_row    <= row;
         s1_win    <= in_win;
         s1_spr    <= spr_c;
         s1_tile   <= tile_c;
         s1_hs     <= hsync_raw;
         s1_vs     <= vsync_raw;
         tb_column <= s1_col;
         tb_row    <= s1_row;
         tb_pixel  <= comp_pix;
         rgb       <= visible ? palette(comp_pix) : '0;
         hs        <= s1_hs;
         vs        <= s1_vs;
      end
   end

   logic [6:0] seg1, seg2;
   assign seg1 = hex_to_seg(sx[7:4]);
   assign seg2 = hex_to_seg(sy[7:4]);

   assign o_VGA_HSync = hs;
   assign o_VGA_VSync = vs;
   assign {o_VGA_Red_2, o_VGA_Red_1, o_VGA_Red_0} = rgb.r;
   assign {o_VGA_Grn_2, o_VGA_Grn_1, o_VGA_Grn_0} = rgb.g;
   assign {o_VGA_Blu_2, o_VGA_Blu_1, o_VGA_Blu_0} = rgb.b;
   assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
           o_Segment1_E, o_Segment1_F, o_Segment1_G} = seg1;
   assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
           o_Segment2_E, o_Segment2_F, o_Segment2_G} = seg2;
   assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = sw_sync;

endmodule

// File: tb/tb_sprites.sv
// Directed bench for sprites: pixel dumps, sync timing, sprite steering and reset.
module tb_sprites;

   logic i_Clk = 1'b0, i_Reset = 1'b1;
   logic i_Switch_1 = 1'b0, i_Switch_2 = 1'b0, i_Switch_3 = 1'b0, i_Switch_4 = 1'b0;
   logic o_VGA_HSync, o_VGA_VSync;
   logic o_VGA_Red_0, o_VGA_Red_1, o_VGA_Red_2;
   logic o_VGA_Grn_0, o_VGA_Grn_1, o_VGA_Grn_2;
   logic o_VGA_Blu_0, o_VGA_Blu_1, o_VGA_Blu_2;
   logic o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D, o_Segment1_E, o_Segment1_F, o_Segment1_G;
   logic o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D, o_Segment2_E, o_Segment2_F, o_Segment2_G;
   logic o_LED_1, o_LED_2, o_LED_3, o_LED_4;
   logic [9:0] tb_row, tb_column;
   logic [1:0] tb_pixel;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_F = 7'b0111000;

   sprites dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset),
      .i_Switch_1(i_Switch_1), .i_Switch_2(i_Switch_2),
      .i_Switch_3(i_Switch_3), .i_Switch_4(i_Switch_4),
      .o_VGA_HSync(o_VGA_HSync), .o_VGA_VSync(o_VGA_VSync),
      .o_VGA_Red_0(o_VGA_Red_0), .o_VGA_Red_1(o_VGA_Red_1), .o_VGA_Red_2(o_VGA_Red_2),
      .o_VGA_Grn_0(o_VGA_Grn_0), .o_VGA_Grn_1(o_VGA_Grn_1), .o_VGA_Grn_2(o_VGA_Grn_2),
      .o_VGA_Blu_0(o_VGA_Blu_0), .o_VGA_Blu_1(o_VGA_Blu_1), .o_VGA_Blu_2(o_VGA_Blu_2),
      .o_Segment1_A(o_Segment1_A), .o_Segment1_B(o_Segment1_B), .o_Segment1_C(o_Segment1_C),
      .o_Segment1_D(o_Segment1_D), .o_Segment1_E(o_Segment1_E), .o_Segment1_F(o_Segment1_F),
      .o_Segment1_G(o_Segment1_G),
      .o_Segment2_A(o_Segment2_A), .o_Segment2_B(o_Segment2_B), .o_Segment2_C(o_Segment2_C),
      .o_Segment2_D(o_Segment2_D), .o_Segment2_E(o_Segment2_E), .o_Segment2_F(o_Segment2_F),
      .o_Segment2_G(o_Segment2_G),
      .o_LED_1(o_LED_1), .o_LED_2(o_LED_2), .o_LED_3(o_LED_3), .o_LED_4(o_LED_4),
      .tb_row(tb_row), .tb_column(tb_column), .tb_pixel(tb_pixel)
   );

   always #20 i_Clk = ~i_Clk;

   logic [8:0] rgb;
   logic [6:0] seg1, seg2;
   assign rgb  = {o_VGA_Red_2, o_VGA_Red_1, o_VGA_Red_0, o_VGA_Grn_2, o_VGA_Grn_1, o_VGA_Grn_0,
                  o_VGA_Blu_2, o_VGA_Blu_1, o_VGA_Blu_0};
   assign seg1 = {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D, o_Segment1_E, o_Segment1_F, o_Segment1_G};
   assign seg2 = {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D, o_Segment2_E, o_Segment2_F, o_Segment2_G};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Jump the raw counters so long waits (frames, far rows) cost a few cycles.
   task automatic jump_to(input logic [9:0] r, input logic [9:0] c);
      @(negedge i_Clk);
      force dut.u_timing.row = r;
      force dut.u_timing.col = c;
      @(posedge i_Clk);
      #1;
      release dut.u_timing.row;
      release dut.u_timing.col;
   endtask

   task automatic step_frames(input int n);
      for (int i = 0; i < n; i++) begin
         jump_to(10'd479, 10'd799);
         repeat (3) @(posedge i_Clk);
      end
      @(negedge i_Clk);
   endtask

   task automatic wait_pix(input int r, input int c, input string tag);
      logic found;
      logic [9:0] rv, cv;
      found = 1'b0;
      rv = r[9:0];
      cv = c[9:0];
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge i_Clk);
         if (tb_row == rv && tb_column == cv) found = 1'b1;
      end
      check({tag, "_reach"}, {31'd0, found}, 32'd1);
   endtask

   task automatic set_switches(input logic [3:0] sw);
      {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = sw;
      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk);
   endtask

   initial begin
      logic [31:0] w0, w1;
      logic [1:0]  p15, p48, p49, p64;
      logic [8:0]  rgb33, rgb49, rgb64;
      int hs_cnt, hs_first, hs_last, rgb_bad, vs_first, vs_last;

      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk);
      check("rst_row", {22'd0, tb_row}, 32'd0);
      check("rst_col", {22'd0, tb_column}, 32'd0);
      check("rst_syncs", {30'd0, o_VGA_HSync, o_VGA_VSync}, 32'd3);
      check("rst_rgb", {23'd0, rgb}, 32'd0);
      check("rst_pixel", {30'd0, tb_pixel}, 32'd0);
      check("rst_leds", {28'd0, o_LED_4, o_LED_3, o_LED_2, o_LED_1}, 32'd0);
      check("rst_seg1", {25'd0, seg1}, {25'd0, SEG_7});
      check("rst_seg2", {25'd0, seg2}, {25'd0, SEG_7});
      i_Reset = 1'b0;

      w0 = '0; w1 = '0; p15 = 2'd3; p48 = 2'd3; p49 = 2'd0; p64 = 2'd0;
      rgb33 = '0; rgb49 = '0; rgb64 = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_Clk);
         if (tb_row == 10'd0) begin
            if (tb_column >= 10'd16 && tb_column <= 10'd31)
               w0[2*(31 - int'(tb_column)) +: 2] = tb_pixel;
            if (tb_column >= 10'd32 && tb_column <= 10'd47)
               w1[2*(47 - int'(tb_column)) +: 2] = tb_pixel;
            if (tb_column == 10'd15) p15 = tb_pixel;
            if (tb_column == 10'd33) rgb33 = rgb;
            if (tb_column == 10'd48) p48 = tb_pixel;
            if (tb_column == 10'd49) begin p49 = tb_pixel; rgb49 = rgb; end
            if (tb_column == 10'd64) begin p64 = tb_pixel; rgb64 = rgb; end
            if (tb_column == 10'd80) break;
         end
      end
      check("row0_c16_31", w0, 32'h00000000);
      check("row0_c32_47", w1, 32'h55555555);
      check("row0_c15_outside", {30'd0, p15}, 32'd0);
      check("rgb_red", {23'd0, rgb33}, 32'h1C0);
      check("pix_c48", {30'd0, p48}, 32'd0);
      check("pix_c49", {30'd0, p49}, 32'd2);
      check("rgb_green", {23'd0, rgb49}, 32'h038);
      check("pix_c64", {30'd0, p64}, 32'd3);
      check("rgb_white", {23'd0, rgb64}, 32'h1FF);

      hs_cnt = 0; hs_first = -1; hs_last = -1; rgb_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge i_Clk);
         if (tb_row != 10'd0) break;
         if (!o_VGA_HSync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(tb_column);
            hs_last = int'(tb_column);
         end
         if (tb_column >= 10'd640 && rgb != 9'd0) rgb_bad++;
      end
      check("hs_count", hs_cnt, 32'd96);
      check("hs_first", hs_first, 32'd656);
      check("hs_last", hs_last, 32'd751);
      check("rgb_blank", rgb_bad, 32'd0);

      jump_to(10'd489, 10'd700);
      vs_first = -1; vs_last = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge i_Clk);
         if (tb_row == 10'd493) break;
         if (!o_VGA_VSync) begin
            if (vs_first < 0) vs_first = int'(tb_row);
            vs_last = int'(tb_row);
         end
      end
      check("vs_first", vs_first, 32'd490);
      check("vs_last", vs_last, 32'd491);

      // Right x3: sx=123. Left edge of sprite lands exactly at window x 125.
      set_switches(4'b1000);
      step_frames(3);
      check("led4", {31'd0, o_LED_4}, 32'd1);
      check("sx123_seg1", {25'd0, seg1}, {25'd0, SEG_7});
      jump_to(10'd124, 10'd700);
      wait_pix(125, 140, "sx123_c140");
      check("sx123_c140", {30'd0, tb_pixel}, 32'd2);
      wait_pix(125, 141, "sx123_c141");
      check("sx123_c141", {30'd0, tb_pixel}, 32'd3);

      // Left x200: sx clamps at 0.
      set_switches(4'b0100);
      step_frames(200);
      check("led3", {31'd0, o_LED_3}, 32'd1);
      check("led4_off", {31'd0, o_LED_4}, 32'd0);
      check("sx0_seg1", {25'd0, seg1}, {25'd0, SEG_0});
      jump_to(10'd129, 10'd700);
      wait_pix(130, 17, "sx0_c17");
      check("sx0_c17", {30'd0, tb_pixel}, 32'd0);
      wait_pix(130, 18, "sx0_c18");
      check("sx0_c18", {30'd0, tb_pixel}, 32'd3);
      wait_pix(130, 29, "sx0_c29");
      check("sx0_c29", {30'd0, tb_pixel}, 32'd3);
      wait_pix(130, 30, "sx0_c30");
      check("sx0_c30", {30'd0, tb_pixel}, 32'd0);

      // Opposing left+right cancel.
      set_switches(4'b1100);
      step_frames(5);
      check("cancel_seg1", {25'd0, seg1}, {25'd0, SEG_0});

      // Right x16 -> sx=16, then down x125 -> sy clamps at 240.
      set_switches(4'b1000);
      step_frames(16);
      check("sx16_seg1", {25'd0, seg1}, {25'd0, SEG_1});
      set_switches(4'b0010);
      step_frames(125);
      check("led2", {31'd0, o_LED_2}, 32'd1);
      check("sy240_seg2", {25'd0, seg2}, {25'd0, SEG_F});
      set_switches(4'b0000);
      jump_to(10'd240, 10'd700);
      wait_pix(241, 34, "sy240_r241");
      check("sy240_r241_c34", {30'd0, tb_pixel}, 32'd0);
      wait_pix(242, 33, "sy240_r242_c33");
      check("sy240_r242_c33", {30'd0, tb_pixel}, 32'd0);
      wait_pix(242, 34, "sy240_r242_c34");
      check("sy240_r242_c34", {30'd0, tb_pixel}, 32'd3);
      check("sy240_rgb", {23'd0, rgb}, 32'h1FF);

      // One-cycle reset mid-line.
      jump_to(10'd100, 10'd300);
      repeat (10) @(negedge i_Clk);
      i_Reset = 1'b1;
      @(negedge i_Clk);
      i_Reset = 1'b0;
      check("mid_rst_row", {22'd0, tb_row}, 32'd0);
      check("mid_rst_col", {22'd0, tb_column}, 32'd0);
      check("mid_rst_syncs", {30'd0, o_VGA_HSync, o_VGA_VSync}, 32'd3);
      check("mid_rst_rgb", {23'd0, rgb}, 32'd0);
      check("mid_rst_seg1", {25'd0, seg1}, {25'd0, SEG_7});
      check("mid_rst_seg2", {25'd0, seg2}, {25'd0, SEG_7});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
